// File: rtl/line_buf_sched.sv
// line_buf_sched: schedules a two-bank line buffer that sits between a PPU pixel writer and a VGA reader.
// Latency: wr_en/wr_addr, rd_addr, vga_en, underrun and line_drop are registered, so each lags its cause by 1 pclk.
// Backpressure: none. The PPU writes whenever it presents a pixel. When no fresh bank is ready, the VGA side repeats its line and sets underrun.
//
// Ports:
//   pclk, rst                     pixel clock; synchronous active-high reset
//   ppu_pix_valid, ppu_line_start PPU pixel strobe and start-of-line pulse
//   vga_h_cnt, vga_line_start     VGA horizontal counter and start-of-line pulse
//   wr_en, wr_addr                buffer write strobe and address {wr_bank, wr_cnt}
//   rd_addr                       buffer read address {rd_bank, vga_h_cnt}
//   vga_en                        enables the VGA timing generator once a line is buffered
//   underrun                      sticky: a VGA line started while no fresh bank was available
//   line_drop                     one-cycle pulse when a partial PPU line is abandoned
//   underrun_cnt                  saturating count of underrun events; present only when
//                                 LINE_BUF_UNDERRUN_CNT_EN is defined
module line_buf_sched #(
    parameter int START_DELAY = 3199,
    parameter int LINE_PIX    = 800,
    parameter int BANK_AW     = 10
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               ppu_pix_valid,
    input  logic               ppu_line_start,
    input  logic [BANK_AW-1:0] vga_h_cnt,
    input  logic               vga_line_start,
    output logic               wr_en,
    output logic [BANK_AW:0]   wr_addr,
    output logic [BANK_AW:0]   rd_addr,
    output logic               vga_en,
    output logic               underrun,
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    output logic [15:0]        underrun_cnt,
`endif
    output logic               line_drop
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_FILL    = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [BANK_AW-1:0] LAST_PIX = BANK_AW'(LINE_PIX - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_start_cnt;
    logic [BANK_AW-1:0] r_wr_cnt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [1:0]         r_full;

    logic               r_wr_en;
    logic [BANK_AW:0]   r_wr_addr;
    logic [BANK_AW:0]   r_rd_addr;
    logic               r_vga_en;
    logic               r_underrun;
    logic               r_line_drop;

    logic               w_run;
    logic               w_startup;
    logic [BANK_AW-1:0] w_wr_cnt_eff;
    logic [BANK_AW-1:0] w_wr_cnt_nxt;
    logic               w_wrap;
    logic               w_bank_done;
    logic [1:0]         w_set_mask;
    logic [1:0]         w_full_pre;
    logic [1:0]         w_full_nxt;
    logic               w_fresh;
    logic               w_swap;
    logic               w_under_evt;
    logic               w_rd_bank_nxt;
    logic               w_drop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STARTUP: if (r_start_cnt == 32'(START_DELAY)) w_state_nxt = ST_FILL;
            // A bank may already have been filled during startup. Leaving FILL on any
            // full bank (not only a new one) avoids a deadlock: after the first line,
            // later completions land on rd_bank and never set a full bit.
            ST_FILL:    if (w_full_pre != 2'b00) w_state_nxt = ST_RUN;
            ST_RUN:     w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_STARTUP;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_run     = 1'b0;
        w_startup = 1'b0;
        case (r_state)
            ST_STARTUP: w_startup = 1'b1;
            ST_RUN:     w_run     = 1'b1;
            default:    ;
        endcase
    end

    // ---------------- write side ----------------
    // A line start in the same cycle as a pixel restarts the line first, so that
    // pixel lands at offset 0.
    assign w_wr_cnt_eff = ppu_line_start ? '0 : r_wr_cnt;
    assign w_wrap       = ppu_pix_valid && (w_wr_cnt_eff == LAST_PIX);
    // A line that finishes in the bank being displayed stays in place. That bank is
    // not marked full and the writer does not advance.
    assign w_bank_done  = w_wrap && (r_wr_bank != r_rd_bank);
    assign w_set_mask   = w_bank_done ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_drop       = ppu_line_start && (r_wr_cnt != '0);

    always_comb begin
        w_wr_cnt_nxt = r_wr_cnt;
        if (ppu_pix_valid) begin
            w_wr_cnt_nxt = w_wrap ? '0 : w_wr_cnt_eff + 1'b1;
        end else if (ppu_line_start) begin
            w_wr_cnt_nxt = '0;
        end
    end

    // ---------------- read side ----------------
    // Full bits are set before they are consumed. A bank that completes in the same
    // cycle as a VGA line start is handed over at once.
    assign w_full_pre    = r_full | w_set_mask;
    assign w_fresh       = w_full_pre[~r_rd_bank];
    assign w_swap        = w_run && vga_line_start && w_fresh;
    assign w_under_evt   = w_run && vga_line_start && !w_fresh;
    assign w_rd_bank_nxt = w_swap ? ~r_rd_bank : r_rd_bank;

    always_comb begin
        w_full_nxt = w_full_pre;
        if (w_swap) begin
            w_full_nxt[~r_rd_bank] = 1'b0;
        end
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_start_cnt <= '0;
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b1;
            r_full      <= 2'b00;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_vga_en    <= 1'b0;
            r_underrun  <= 1'b0;
            r_line_drop <= 1'b0;
        end else begin
            if (w_startup && (r_start_cnt != 32'(START_DELAY))) begin
                r_start_cnt <= r_start_cnt + 32'd1;
            end
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_wr_bank   <= w_bank_done ? ~r_wr_bank : r_wr_bank;
            r_rd_bank   <= w_rd_bank_nxt;
            r_full      <= w_full_nxt;
            r_wr_en     <= ppu_pix_valid;
            r_wr_addr   <= {r_wr_bank, w_wr_cnt_eff};
            r_rd_addr   <= {w_rd_bank_nxt, vga_h_cnt};
            r_vga_en    <= w_run;
            r_underrun  <= r_underrun | w_under_evt;
            r_line_drop <= w_drop;
        end
    end

`ifdef LINE_BUF_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_under_evt && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign rd_addr   = r_rd_addr;
    assign vga_en    = r_vga_en;
    assign underrun  = r_underrun;
    assign line_drop = r_line_drop;

endmodule

// File: tb/tb_line_buf_sched.sv
// tb_line_buf_sched: directed testbench for line_buf_sched with default parameters.
// Latency: every step drives the inputs, waits one pclk edge and then checks the registered outputs 1 ns later.
// Backpressure: none. Write addresses are queued at the time each pixel is driven and popped when wr_en appears.
module tb_line_buf_sched;

    logic        pclk;
    logic        rst;
    logic        ppu_pix_valid;
    logic        ppu_line_start;
    logic [9:0]  vga_h_cnt;
    logic        vga_line_start;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [10:0] rd_addr;
    logic        vga_en;
    logic        underrun;
    logic        line_drop;
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    line_buf_sched dut (
        .pclk           (pclk),
        .rst            (rst),
        .ppu_pix_valid  (ppu_pix_valid),
        .ppu_line_start (ppu_line_start),
        .vga_h_cnt      (vga_h_cnt),
        .vga_line_start (vga_line_start),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .rd_addr        (rd_addr),
        .vga_en         (vga_en),
        .underrun       (underrun),
`ifdef LINE_BUF_UNDERRUN_CNT_EN
        .underrun_cnt   (underrun_cnt),
`endif
        .line_drop      (line_drop)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] exp_q[$];

    // Expected-state of the bench: write pointer plus directed read-side expectations.
    int m_cnt;
    int m_bank;
    int m_rd;
    int m_rd_next;
    int m_ven;
    int m_und;
    int m_ucnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_bank    = 0;
        m_rd      = 1;
        m_rd_next = 1;
        m_ven     = 0;
        m_und     = 0;
        m_ucnt    = 0;
        exp_q.delete();
    endtask

    // Hold rst for n cycles. The other inputs are driven busy during reset; all of
    // them must be ignored.
    task automatic do_reset(input int n);
        rst            = 1'b1;
        ppu_pix_valid  = 1'b1;
        ppu_line_start = 1'b1;
        vga_line_start = 1'b1;
        vga_h_cnt      = 10'd7;
        repeat (n) @(posedge pclk);
        #1;
        chk("rst_vga_en", vga_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_line_drop", line_drop, 0);
`ifdef LINE_BUF_UNDERRUN_CNT_EN
        chk("rst_underrun_cnt", underrun_cnt, 0);
`endif
        rst            = 1'b0;
        ppu_pix_valid  = 1'b0;
        ppu_line_start = 1'b0;
        vga_line_start = 1'b0;
        vga_h_cnt      = 10'd0;
        model_reset();
    endtask

    // One pclk cycle of stimulus followed by checks of every output.
    task automatic step(input logic v, input logic ls, input logic vls, input logic [9:0] h);
        int   eff;
        logic exp_ld;
        ppu_pix_valid  = v;
        ppu_line_start = ls;
        vga_line_start = vls;
        vga_h_cnt      = h;
        exp_ld = ls && (m_cnt != 0);
        if (v) begin
            eff = ls ? 0 : m_cnt;
            exp_q.push_back(11'(m_bank * 1024 + eff));
            m_cnt = eff + 1;
            if (m_cnt == 800) begin
                m_cnt = 0;
                if (m_bank != m_rd) m_bank = 1 - m_bank;
            end
        end else if (ls) begin
            m_cnt = 0;
        end
        @(posedge pclk);
        #1;
        m_rd = m_rd_next;
        chk("wr_en", wr_en, v);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_addr", wr_addr, exp_q.pop_front());
        end
        chk("line_drop", line_drop, exp_ld);
        chk("rd_addr", rd_addr, m_rd * 1024 + h);
        chk("vga_en", vga_en, m_ven);
        chk("underrun", underrun, m_und);
`ifdef LINE_BUF_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, m_ucnt);
`endif
    endtask

    task automatic pixels(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 10'd0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 10'd0);
        end
    endtask

    initial begin
        model_reset();
        do_reset(3);

        // Startup: no pixels, vga_en must stay low through and past the wait.
        for (int i = 0; i < 3205; i++) step(1'b0, 1'b0, 1'b0, 10'd0);

        // First line, one pixel every 2nd cycle, into bank 0 (addresses 0..799).
        pixels(799, 1);
        step(1'b1, 1'b0, 1'b0, 10'd0);      // completes bank 0 -> RUN, vga_en not yet
        m_ven = 1;
        step(1'b0, 1'b0, 1'b0, 10'd0);      // vga_en rises one cycle after RUN

        // Second line into bank 1 (1024..1823). Bank 1 is being displayed, so it wraps in place.
        pixels(800, 1);

        // Partial line of 300 then a line start: one drop pulse, restart at offset 0.
        pixels(300, 0);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0);      // wr_cnt already 0: no drop
        pixels(10, 0);                       // 1024..1033
        step(1'b1, 1'b1, 1'b0, 10'd0);      // drop + pixel written at 1024

        // VGA line start with bank 0 full: swap to bank 0.
        m_rd_next = 0;
        step(1'b0, 1'b0, 1'b1, 10'd0);
        step(1'b0, 1'b0, 1'b0, 10'd5);

        // Finish bank 1 in the same cycle as a VGA line start: swap, no underrun.
        pixels(798, 0);
        m_rd_next = 1;
        step(1'b1, 1'b0, 1'b1, 10'd0);

        // Another VGA line with nothing fresh: bank held, underrun set and sticky.
        m_und  = 1;
        m_ucnt = 1;
        step(1'b0, 1'b0, 1'b1, 10'd0);
        step(1'b0, 1'b0, 1'b0, 10'd3);

        // Fill bank 0 and swap onto it. Bank 1 was consumed above, so the next start holds.
        pixels(800, 0);
        m_rd_next = 0;
        step(1'b0, 1'b0, 1'b1, 10'd0);
        m_ucnt = 2;
        step(1'b0, 1'b0, 1'b1, 10'd9);

        // Reset in the middle of a line while running.
        pixels(50, 0);
        do_reset(1);
        pixels(2, 0);                        // restarts at bank 0 offset 0
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 10'd0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buf_sched.md
LINE_BUF_SCHED -- requirements
Module: line_buf_sched

Interface
REQ-001 SHALL have parameter START_DELAY, default 3199, startup wait in pclk cycles before vga_en may assert.
REQ-002 SHALL have parameter LINE_PIX, default 800, pixels per line written to and read from one bank.
REQ-003 SHALL have parameter BANK_AW, default 10, address width within one bank (bank size 2^BANK_AW, LINE_PIX <= 2^BANK_AW).
REQ-004 SHALL have ports: pclk input 1, pixel clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have port ppu_pix_valid input 1, one PPU pixel present this cycle.
REQ-006 SHALL have port ppu_line_start input 1, single-cycle pulse marking the start of a PPU line.
REQ-007 SHALL have port vga_h_cnt input BANK_AW, VGA horizontal pixel counter.
REQ-008 SHALL have port vga_line_start input 1, single-cycle pulse when vga_h_cnt is 0.
REQ-009 SHALL have ports wr_en output 1 and wr_addr output BANK_AW+1, buffer write strobe and address {wr_bank, wr_cnt}.
REQ-010 SHALL have port rd_addr output BANK_AW+1, buffer read address {rd_bank, vga_h_cnt}.
REQ-011 SHALL have port vga_en output 1, enable for the VGA timing generator.
REQ-012 SHALL have port underrun output 1, sticky flag set when a VGA line starts with no fresh bank.
REQ-013 SHALL have port line_drop output 1, single-cycle pulse when a partial PPU line is discarded.

Function
REQ-014 SHALL implement states STARTUP, FILL, RUN; STARTUP counts pclk cycles, exits to FILL when count reaches START_DELAY.
REQ-015 FILL SHALL go to RUN on the first cycle a bank becomes full; RUN SHALL persist until reset.
REQ-016 vga_en SHALL be 1 only in RUN (registered, asserts the cycle after entering RUN).
REQ-017 In all states, wr_en SHALL equal ppu_pix_valid registered (1-cycle latency), with wr_addr the address sampled alongside.
REQ-018 wr_cnt SHALL increment on each ppu_pix_valid; on the valid where wr_cnt == LINE_PIX-1 it SHALL wrap to 0, set full[wr_bank], toggle wr_bank.
REQ-019 ppu_line_start with wr_cnt != 0 SHALL reset wr_cnt to 0, keep wr_bank, pulse line_drop; with wr_cnt == 0 no effect.
REQ-020 ppu_line_start and ppu_pix_valid in the same cycle: reset applies first, the pixel SHALL be written at offset 0 and wr_cnt becomes 1.
REQ-021 On vga_line_start in RUN: if full[~rd_bank], rd_bank SHALL toggle and full[~rd_bank] clear; otherwise rd_bank SHALL hold (line repeated) and underrun SHALL set.
REQ-022 Bank completion into the bank currently selected as rd_bank SHALL be impossible: if wr_bank == rd_bank at wrap, wr_bank SHALL NOT toggle and the line is overwritten in place (full not set).
REQ-023 Simultaneous completion setting full[b] and vga_line_start consuming full[b] SHALL result in the swap occurring and full[b] cleared.
REQ-024 rd_addr SHALL be registered: {rd_bank after any same-cycle swap, vga_h_cnt}, 1-cycle latency.
REQ-025 underrun SHALL not assert in STARTUP or FILL.

Reset
REQ-026 On rst: state STARTUP, counter 0, wr_cnt 0, wr_bank 0, rd_bank 1, full 2'b00.
REQ-027 On rst: vga_en 0, wr_en 0, wr_addr 0, rd_addr 0, underrun 0, line_drop 0; rst mid-line SHALL abandon the line with no line_drop pulse.

Configuration
REQ-028 Macro LINE_BUF_UNDERRUN_CNT_EN defined: SHALL add output underrun_cnt 16 bits, incremented per underrun event, saturating at 16'hFFFF, reset to 0.
REQ-029 Macro LINE_BUF_UNDERRUN_CNT_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Release rst, no pixels -> vga_en stays 0; after 3200 cycles plus one full 800-pixel line -> vga_en 1 one cycle after entering RUN.
REQ-031 Valid every 2nd cycle, 800 pixels -> wr_addr 0..799 then wr_bank 1; second line -> addresses 1024..1823.
REQ-032 ppu_line_start after 300 pixels -> line_drop one pulse, next pixel wr_addr = bank*1024+0.
REQ-033 In RUN, two vga_line_start with no new PPU line -> rd_addr bank held on second, underrun 1 (underrun_cnt 1 with macro).
REQ-034 Bank completion and vga_line_start in same cycle -> rd_bank toggles, full bit cleared, underrun stays 0.
REQ-035 rst asserted mid-line in RUN -> next cycle vga_en 0, wr_cnt 0, full 00, no line_drop.
